// File: rtl/alu_pkg.sv
// Shared decode tables, internal op/state enums and the pure decode function for alu_exec_unit.
// Mul/div/mfhi/mflo decode only when ALU_MDU_EN is defined.
package alu_pkg;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_AND  = 3'b010;
    localparam logic [2:0] ALUOP_OR   = 3'b011;
    localparam logic [2:0] ALUOP_XOR  = 3'b100;
    localparam logic [2:0] ALUOP_SLT  = 3'b101;
    localparam logic [2:0] ALUOP_SLTU = 3'b110;
    localparam logic [2:0] ALUOP_LUI  = 3'b111;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_LUI, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
    } op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;

    // add/addu (and sub/subu) share one op; ovf_en separates the trapping flavour
    typedef struct packed {
        op_e  op;
        logic ovf_en;
    } dec_t;

    function automatic dec_t decode(input logic rtype, input logic [2:0] aluop,
                                    input logic [5:0] func);
        dec_t d;
        d.op     = OP_ILL;
        d.ovf_en = 1'b0;
        if (!rtype) begin
            case (aluop)
                ALUOP_ADD:  d.op = OP_ADD;
                ALUOP_SUB:  d.op = OP_SUB;
                ALUOP_AND:  d.op = OP_AND;
                ALUOP_OR:   d.op = OP_OR;
                ALUOP_XOR:  d.op = OP_XOR;
                ALUOP_SLT:  d.op = OP_SLT;
                ALUOP_SLTU: d.op = OP_SLTU;
                ALUOP_LUI:  d.op = OP_LUI;
            endcase
        end else begin
            case (func)
                FN_ADD:   begin d.op = OP_ADD; d.ovf_en = 1'b1; end
                FN_ADDU:  d.op = OP_ADD;
                FN_SUB:   begin d.op = OP_SUB; d.ovf_en = 1'b1; end
                FN_SUBU:  d.op = OP_SUB;
                FN_AND:   d.op = OP_AND;
                FN_OR:    d.op = OP_OR;
                FN_XOR:   d.op = OP_XOR;
                FN_NOR:   d.op = OP_NOR;
                FN_SLT:   d.op = OP_SLT;
                FN_SLTU:  d.op = OP_SLTU;
`ifdef ALU_MDU_EN
                FN_MFHI:  d.op = OP_MFHI;
                FN_MFLO:  d.op = OP_MFLO;
                FN_MULT:  d.op = OP_MULT;
                FN_MULTU: d.op = OP_MULTU;
                FN_DIV:   d.op = OP_DIV;
                FN_DIVU:  d.op = OP_DIVU;
`endif
                default:  d.op = OP_ILL;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the EX-stage pipeline (master) and alu_exec_unit (slave).
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    logic             valid_in;
    logic [2:0]       aluop;
    logic [5:0]       func;
    logic             rtype;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid_in, aluop, func, rtype, a, b,
        input  ready, result_valid, result, zero, overflow, illegal, div0, hi, lo
    );
    modport slave (
        input  valid_in, aluop, func, rtype, a, b,
        output ready, result_valid, result, zero, overflow, illegal, div0, hi, lo
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider on operand magnitudes.
// done is combinational on the last iteration cycle; res_hi/res_lo carry the signed-fixed result then.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             run,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    logic                 sa, sb, ge;
    logic [WIDTH-1:0]     ma, mb, m_q, q_mag, r_mag;
    logic [WIDTH:0]       rs, acc;
    logic [2*WIDTH-1:0]   p_q, p_nxt, prod;
    logic                 div_q, neg_q, negr_q;
    logic [CNT_W-1:0]     cnt_q;

    assign sa = is_signed & a[WIDTH-1];
    assign sb = is_signed & b[WIDTH-1];
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;

    // p_q holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        rs  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        ge  = (rs >= {1'b0, m_q});
        acc = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        if (div_q)
            p_nxt = {(ge ? rs[WIDTH-1:0] - m_q : rs[WIDTH-1:0]), p_q[WIDTH-2:0], ge};
        else
            p_nxt = {acc, p_q[WIDTH-1:1]};
    end

    always_comb begin
        prod  = neg_q ? -p_nxt : p_nxt;
        q_mag = p_nxt[WIDTH-1:0];
        r_mag = p_nxt[2*WIDTH-1:WIDTH];
        if (div_q) begin
            res_lo = neg_q  ? -q_mag : q_mag;
            res_hi = negr_q ? -r_mag : r_mag;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    assign done = run && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= '0;
            m_q    <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            p_q    <= {{WIDTH{1'b0}}, (is_div ? ma : mb)};
            m_q    <= is_div ? mb : ma;
            div_q  <= is_div;
            neg_q  <= sa ^ sb;
            negr_q <= sa;
            cnt_q  <= '0;
        end else if (run) begin
            p_q    <= p_nxt;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ops with one registered stage, plus iterative mul/div with HI/LO.
// Build option ALU_MDU_EN enables the mul/div unit; without it those funcs decode illegal and ready is 1.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);
    dec_t             dec;
    logic             accept, ready, ovf_c, div0_c, mdu_start, mdu_done;
    logic             rv_q, ovf_q, ill_q, div0_q;
    logic [WIDTH-1:0] a, b, sum, dif, alu_res, hi_q, lo_q, mdu_lo, result_q;

    assign a      = bus.a;
    assign b      = bus.b;
    assign dec    = decode(bus.rtype, bus.aluop, bus.func);
    assign accept = bus.valid_in & ready;
    assign sum    = a + b;
    assign dif    = a - b;
    assign div0_c = (dec.op == OP_DIV || dec.op == OP_DIVU) && (b == '0);

    always_comb begin
        alu_res = '0;
        ovf_c   = 1'b0;
        case (dec.op)
            OP_ADD: begin
                alu_res = sum;
                ovf_c   = dec.ovf_en && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                ovf_c   = dec.ovf_en && (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_LUI:  alu_res = b << (WIDTH / 2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            // only reached single-cycle on divide-by-zero, where result mirrors lo
            OP_DIV, OP_DIVU: alu_res = '1;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MDU_EN
    state_e           st_q, st_d;
    logic             is_div;
    logic [WIDTH-1:0] mdu_hi;

    assign is_div    = (dec.op == OP_DIV || dec.op == OP_DIVU);
    assign mdu_start = accept && !div0_c && (is_div || dec.op == OP_MULT || dec.op == OP_MULTU);
    assign ready     = (st_q == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= ST_IDLE;
        else     st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:        if (mdu_start) st_d = is_div ? ST_DIV : ST_MUL;
            ST_MUL, ST_DIV: if (mdu_done)  st_d = ST_IDLE;
            default:        st_d = ST_IDLE;
        endcase
    end

    alu_mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .start     (mdu_start),
        .is_div    (is_div),
        .is_signed (dec.op == OP_MULT || dec.op == OP_DIV),
        .a         (a),
        .b         (b),
        .run       (st_q != ST_IDLE),
        .done      (mdu_done),
        .res_hi    (mdu_hi),
        .res_lo    (mdu_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (accept && div0_c) begin
            hi_q <= a;
            lo_q <= '1;
        end else if (mdu_done) begin
            hi_q <= mdu_hi;
            lo_q <= mdu_lo;
        end
    end
`else
    wire [CNT_W-1:0] unused_cnt = '0;
    assign ready     = 1'b1;
    assign mdu_start = 1'b0;
    assign mdu_done  = 1'b0;
    assign mdu_lo    = '0;
    assign hi_q      = '0;
    assign lo_q      = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q     <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            rv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            ill_q  <= 1'b0;
            div0_q <= 1'b0;
            if (accept && !mdu_start) begin
                rv_q     <= 1'b1;
                result_q <= alu_res;
                ovf_q    <= ovf_c;
                ill_q    <= (dec.op == OP_ILL);
                div0_q   <= div0_c;
            end else if (mdu_done) begin
                rv_q     <= 1'b1;
                result_q <= mdu_lo;
            end
        end
    end

    assign bus.ready        = ready;
    assign bus.result_valid = rv_q;
    assign bus.result       = result_q;
    assign bus.zero         = rv_q && (result_q == '0);
    assign bus.overflow     = ovf_q;
    assign bus.illegal      = ill_q;
    assign bus.div0         = div0_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; mul/div scenarios are selected by ALU_MDU_EN.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit_if #(.WIDTH(32)) bus ();
    alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rt;
        logic [2:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ov;
        logic        ill;
    } vec_t;

    // drive one issue, let the clock accept it, and return #1 after that edge
    task automatic issue(input logic rt, input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] aa, input logic [31:0] bb);
        bus.rtype = rt; bus.aluop = op; bus.func = fn; bus.a = aa; bus.b = bb;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.valid_in = 1'b0; bus.rtype = 1'b0; bus.aluop = 3'd0; bus.func = 6'd0;
        bus.a = 32'h0; bus.b = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ready, bus.result_valid, bus.zero, bus.overflow, bus.illegal, bus.div0} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got rdy/rv/z/ov/ill/d0=%b expected 100000",
                     {bus.ready, bus.result_valid, bus.zero, bus.overflow, bus.illegal, bus.div0});
        end
        checks++;
        if ({bus.result, bus.hi, bus.lo} !== 96'h0) begin
            errors++;
            $display("FAIL reset_regs: got result=%h hi=%h lo=%h expected all 0", bus.result, bus.hi, bus.lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_ops();
        vec_t v [17];
        v[0]  = '{1'b1, 3'd0, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
        v[1]  = '{1'b1, 3'd0, 6'b100001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
        v[2]  = '{1'b1, 3'd0, 6'b100010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0};
        v[3]  = '{1'b1, 3'd0, 6'b100011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0};
        v[4]  = '{1'b0, 3'b000, 6'b111111, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
        v[5]  = '{1'b0, 3'b101, 6'b000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        v[6]  = '{1'b0, 3'b110, 6'b000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        v[7]  = '{1'b0, 3'b111, 6'b000000, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0};
        v[8]  = '{1'b1, 3'd0, 6'b100100, 32'hF0F01234, 32'h0FF000FF, 32'h00F00034, 1'b0, 1'b0};
        v[9]  = '{1'b1, 3'd0, 6'b100101, 32'hF0F01234, 32'h0FF000FF, 32'hFFF012FF, 1'b0, 1'b0};
        v[10] = '{1'b1, 3'd0, 6'b100110, 32'hF0F01234, 32'h0FF000FF, 32'hFF0012CB, 1'b0, 1'b0};
        v[11] = '{1'b1, 3'd0, 6'b100111, 32'hF0F01234, 32'h0FF000FF, 32'h000FED00, 1'b0, 1'b0};
        v[12] = '{1'b1, 3'd0, 6'b101010, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        v[13] = '{1'b1, 3'd0, 6'b101011, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        v[14] = '{1'b0, 3'b001, 6'b000000, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        v[15] = '{1'b0, 3'b010, 6'b000000, 32'hFFFF0000, 32'h12345678, 32'h12340000, 1'b0, 1'b0};
        v[16] = '{1'b1, 3'd0, 6'b111111, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b1};
        for (int i = 0; i < 17; i++) begin
            issue(v[i].rt, v[i].op, v[i].fn, v[i].a, v[i].b);
            checks++;
            if ({bus.result_valid, bus.result, bus.overflow, bus.illegal, bus.zero} !==
                {1'b1, v[i].res, v[i].ov, v[i].ill, (v[i].res == 32'h0)}) begin
                errors++;
                $display("FAIL alu_op[%0d]: got rv=%b res=%h ov=%b ill=%b z=%b expected rv=1 res=%h ov=%b ill=%b",
                         i, bus.result_valid, bus.result, bus.overflow, bus.illegal, bus.zero,
                         v[i].res, v[i].ov, v[i].ill);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.rtype = 1'b1; bus.func = 6'b100001; bus.a = 32'd1; bus.b = 32'd2; bus.valid_in = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.result_valid, bus.ready, bus.result} !== {1'b1, 1'b1, 32'd3}) begin
            errors++;
            $display("FAIL b2b_first: got rv=%b rdy=%b res=%h expected rv=1 rdy=1 res=00000003",
                     bus.result_valid, bus.ready, bus.result);
        end
        bus.func = 6'b100011; bus.a = 32'd10; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        checks++;
        if ({bus.result_valid, bus.result} !== {1'b1, 32'd7}) begin
            errors++;
            $display("FAIL b2b_second: got rv=%b res=%h expected rv=1 res=00000007", bus.result_valid, bus.result);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.result_valid, bus.zero, bus.result} !== {1'b0, 1'b0, 32'd7}) begin
            errors++;
            $display("FAIL b2b_idle: got rv=%b z=%b res=%h expected rv=0 z=0 res=00000007",
                     bus.result_valid, bus.zero, bus.result);
        end
    endtask

`ifdef ALU_MDU_EN
    // issues a mul/div, checks the 32-cycle busy window (with an ignored issue inside it) and completion
    task automatic run_mdu(input string nm, input logic [5:0] fn, input logic [31:0] aa,
                           input logic [31:0] bb, input logic [31:0] ehi, input logic [31:0] elo);
        bit busy_ok = 1'b1;
        issue(1'b1, 3'd0, fn, aa, bb);
        for (int i = 1; i <= 32; i++) begin
            if (bus.ready !== 1'b0 || bus.result_valid !== 1'b0) busy_ok = 1'b0;
            if (i == 10) begin
                bus.func = 6'b100001; bus.a = 32'd1; bus.b = 32'd1; bus.valid_in = 1'b1;
            end else begin
                bus.valid_in = 1'b0;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s_busy: got ready/result_valid not held at 0/0 for 32 cycles expected busy", nm);
        end
        checks++;
        if ({bus.result_valid, bus.ready, bus.result, bus.hi, bus.lo} !== {1'b1, 1'b1, elo, ehi, elo}) begin
            errors++;
            $display("FAIL %s_done: got rv=%b rdy=%b res=%h hi=%h lo=%h expected rv=1 rdy=1 res=%h hi=%h lo=%h",
                     nm, bus.result_valid, bus.ready, bus.result, bus.hi, bus.lo, elo, ehi, elo);
        end
    endtask

    task automatic test_mult();
        run_mdu("mult", 6'b011000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        @(posedge clk); #1;
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL mult_no_extra_pulse: got rv=%b expected 0", bus.result_valid);
        end
        run_mdu("multu", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        issue(1'b1, 3'd0, 6'b010000, 32'h0, 32'h0);
        checks++;
        if ({bus.result_valid, bus.result} !== {1'b1, 32'hFFFFFFFE}) begin
            errors++;
            $display("FAIL mfhi_completion: got rv=%b res=%h expected rv=1 res=FFFFFFFE", bus.result_valid, bus.result);
        end
        issue(1'b1, 3'd0, 6'b010010, 32'h0, 32'h0);
        checks++;
        if ({bus.result_valid, bus.result} !== {1'b1, 32'h00000001}) begin
            errors++;
            $display("FAIL mflo: got rv=%b res=%h expected rv=1 res=00000001", bus.result_valid, bus.result);
        end
    endtask

    task automatic test_div();
        run_mdu("div_neg", 6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_mdu("div_negdivisor", 6'b011010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_mdu("divu", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_mdu("div_minneg", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        issue(1'b1, 3'd0, 6'b011011, 32'h12345678, 32'h0);
        checks++;
        if ({bus.result_valid, bus.div0, bus.ready, bus.result, bus.lo, bus.hi} !==
            {1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678}) begin
            errors++;
            $display("FAIL div0: got rv=%b d0=%b rdy=%b res=%h lo=%h hi=%h expected 1 1 1 FFFFFFFF FFFFFFFF 12345678",
                     bus.result_valid, bus.div0, bus.ready, bus.result, bus.lo, bus.hi);
        end
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        issue(1'b1, 3'd0, 6'b011000, 32'd3, 32'd4);
        repeat (9) begin @(posedge clk); #1; end
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy: got ready=%b expected 0", bus.ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ready, bus.result_valid, bus.hi, bus.lo} !== {1'b1, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL rstmid_clear: got rdy=%b rv=%b hi=%h lo=%h expected 1 0 0 0",
                     bus.ready, bus.result_valid, bus.hi, bus.lo);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.result_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL rstmid_no_pulse: got result_valid pulse after reset expected none");
        end
        issue(1'b1, 3'd0, 6'b100000, 32'd2, 32'd3);
        checks++;
        if ({bus.result_valid, bus.result} !== {1'b1, 32'd5}) begin
            errors++;
            $display("FAIL rstmid_add: got rv=%b res=%h expected rv=1 res=00000005", bus.result_valid, bus.result);
        end
    endtask
`else
    task automatic test_mdu_disabled();
        logic [5:0] fns [6];
        fns[0] = 6'b011000; fns[1] = 6'b011001; fns[2] = 6'b011010;
        fns[3] = 6'b011011; fns[4] = 6'b010000; fns[5] = 6'b010010;
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 3'd0, fns[i], 32'h00001234, 32'h0);
            checks++;
            if ({bus.result_valid, bus.illegal, bus.div0, bus.ready, bus.result, bus.hi, bus.lo} !==
                {1'b1, 1'b1, 1'b0, 1'b1, 96'h0}) begin
                errors++;
                $display("FAIL mdu_off[%0d]: got rv=%b ill=%b d0=%b rdy=%b res=%h hi=%h lo=%h expected 1 1 0 1 0 0 0",
                         i, bus.result_valid, bus.illegal, bus.div0, bus.ready, bus.result, bus.hi, bus.lo);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ops();
        test_back_to_back();
`ifdef ALU_MDU_EN
        test_mult();
        test_div();
        test_reset_mid();
`else
        test_mdu_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
